// File: rtl/bpm_deswap_avg_pkg.sv
// bpm_deswap_avg_pkg: shared BPM types and default widths for the swap and deswap stages.
package bpm_deswap_avg_pkg;
  localparam int ADC_WIDTH_DEF = 16;
  localparam int ACC_WIDTH_DEF = 32;
  localparam int SHIFT_W = 5;
  typedef enum logic {SW_DIRECT = 1'b0, SW_CROSSED = 1'b1} swap_e;
  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_ACC} avg_state_e;
endpackage

// File: rtl/bpm_deswap_acc.sv
// bpm_deswap_acc: single-channel signed accumulator with clear, load and add controls.
module bpm_deswap_acc
  import bpm_deswap_avg_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  input  logic                 ld_i,
  input  logic                 add_i,
  input  logic [ADC_WIDTH-1:0] din_i,
  output logic [ACC_WIDTH-1:0] sum_o
);
  logic [ACC_WIDTH-1:0] sum_d, sum_q, ext;
  always_comb begin
    ext   = {{(ACC_WIDTH-ADC_WIDTH){din_i[ADC_WIDTH-1]}}, din_i};
    sum_d = clr_i ? '0 : ld_i ? ext : add_i ? sum_q + ext : sum_q;
  end
  always_ff @(posedge clk_sys_i or negedge rst_n_i)
    if (!rst_n_i) sum_q <= '0;
    else sum_q <= sum_d;
  assign sum_o = sum_q;
endmodule

// File: rtl/bpm_deswap_avg.sv
// bpm_deswap_avg: undoes the ADC channel swap and averages each channel over whole swap periods.
module bpm_deswap_avg
  import bpm_deswap_avg_pkg::*;
#(
  parameter int ADC_WIDTH = ADC_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF
) (
  input  logic                 clk_sys_i,
  input  logic                 rst_n_i,
  input  logic [ADC_WIDTH-1:0] cha_i,
  input  logic [ADC_WIDTH-1:0] chb_i,
  input  logic [ADC_WIDTH-1:0] chc_i,
  input  logic [ADC_WIDTH-1:0] chd_i,
  input  logic                 valid_i,
  input  logic                 swap_i,
  input  logic                 en_i,
  input  logic [SHIFT_W-1:0]   shift_i,
  output logic [ADC_WIDTH-1:0] cha_o,
  output logic [ADC_WIDTH-1:0] chb_o,
  output logic [ADC_WIDTH-1:0] chc_o,
  output logic [ADC_WIDTH-1:0] chd_o,
  output logic                 valid_o,
  output logic [ADC_WIDTH-1:0] avg_a_o,
  output logic [ADC_WIDTH-1:0] avg_b_o,
  output logic [ADC_WIDTH-1:0] avg_c_o,
  output logic [ADC_WIDTH-1:0] avg_d_o,
  output logic                 avg_valid_o,
  output logic                 period_err_o
);
  localparam int SH_MAX = ACC_WIDTH - ADC_WIDTH;
  localparam int CNT_W = SH_MAX + 1;
  localparam logic [SHIFT_W-1:0] SH_CAP = (SH_MAX > 31) ? 5'd31 : SHIFT_W'(SH_MAX);
  avg_state_e state_q, state_d;
  logic [ADC_WIDTH-1:0] ds [4];
  logic [ADC_WIDTH-1:0] dout_q [4], dout_d [4], avg_q [4], avg_d [4];
  logic [ACC_WIDTH-1:0] sum [4];
  logic [CNT_W-1:0] cnt_q, cnt_d, target;
  logic [SHIFT_W-1:0] sh_q, sh_d, sh_new;
  logic valid_q, prev_q, prev_d, en_q, err_q, err_d, avg_valid_q;
  logic start, clr, ld, add, close_ok, close_bad, upd;
  assign ds[0] = (swap_i == SW_CROSSED) ? chc_i : cha_i;
  assign ds[1] = (swap_i == SW_CROSSED) ? chd_i : chb_i;
  assign ds[2] = (swap_i == SW_CROSSED) ? cha_i : chc_i;
  assign ds[3] = (swap_i == SW_CROSSED) ? chb_i : chd_i;
  // A period opens on the first valid direct sample after a crossed one.
  assign start  = valid_i && swap_i == SW_DIRECT && prev_q == SW_CROSSED;
  assign prev_d = valid_i ? swap_i : prev_q;
  assign sh_new = (shift_i > SH_CAP) ? SH_CAP : shift_i;
  assign target = CNT_W'(1) << sh_q;
  always_comb begin
    state_d   = state_q;
    clr       = 1'b0;
    ld        = 1'b0;
    add       = 1'b0;
    close_ok  = 1'b0;
    close_bad = 1'b0;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    unique case (state_q)
      ST_IDLE: begin
        clr   = 1'b1;
        cnt_d = '0;
        if (en_i) state_d = ST_SYNC;
      end
      ST_SYNC: if (start) begin
        state_d = ST_ACC;
        ld      = 1'b1;
        cnt_d   = CNT_W'(1);
        sh_d    = sh_new;
      end
      ST_ACC: if (start) begin
        ld        = 1'b1;
        cnt_d     = CNT_W'(1);
        sh_d      = sh_new;
        close_ok  = cnt_q == target;
        close_bad = cnt_q != target;
      end else if (valid_i) begin
        add   = 1'b1;
        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en_i) begin
      state_d   = ST_IDLE;
      clr       = 1'b1;
      ld        = 1'b0;
      add       = 1'b0;
      close_ok  = 1'b0;
      close_bad = 1'b0;
      cnt_d     = '0;
    end
  end
  // Once a window mismatch is flagged, averages stay frozen until en_i is re-armed.
  assign upd   = close_ok && !err_q;
  assign err_d = (en_i && !en_q) ? 1'b0 : err_q | close_bad;
  always_comb
    for (int i = 0; i < 4; i++) begin
      dout_d[i] = valid_i ? ds[i] : dout_q[i];
      avg_d[i]  = upd ? ADC_WIDTH'($signed(sum[i]) >>> sh_q) : avg_q[i];
    end
  for (genvar i = 0; i < 4; i++) begin : g_acc
    bpm_deswap_acc #(.ADC_WIDTH(ADC_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_acc (
      .clk_sys_i(clk_sys_i),
      .rst_n_i  (rst_n_i),
      .clr_i    (clr),
      .ld_i     (ld),
      .add_i    (add),
      .din_i    (ds[i]),
      .sum_o    (sum[i])
    );
  end
  always_ff @(posedge clk_sys_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      valid_q     <= 1'b0;
      prev_q      <= 1'b0;
      en_q        <= 1'b0;
      err_q       <= 1'b0;
      avg_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        dout_q[i] <= '0;
        avg_q[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      valid_q     <= valid_i;
      prev_q      <= prev_d;
      en_q        <= en_i;
      err_q       <= err_d;
      avg_valid_q <= upd;
      dout_q      <= dout_d;
      avg_q       <= avg_d;
    end
  assign cha_o        = dout_q[0];
  assign chb_o        = dout_q[1];
  assign chc_o        = dout_q[2];
  assign chd_o        = dout_q[3];
  assign valid_o      = valid_q;
  assign avg_a_o      = avg_q[0];
  assign avg_b_o      = avg_q[1];
  assign avg_c_o      = avg_q[2];
  assign avg_d_o      = avg_q[3];
  assign avg_valid_o  = avg_valid_q;
  assign period_err_o = err_q;
endmodule

// File: tb/tb_bpm_deswap_avg.sv
// tb_bpm_deswap_avg: directed vectors with hand-computed expectations for bpm_deswap_avg.
module tb_bpm_deswap_avg;
  import bpm_deswap_avg_pkg::*;
  logic clk = 1'b0;
  logic rst_n_i = 1'b1;
  logic [15:0] cha_i = '0, chb_i = '0, chc_i = '0, chd_i = '0;
  logic valid_i = 1'b0, swap_i = 1'b0, en_i = 1'b0;
  logic [4:0] shift_i = 5'd3;
  logic [15:0] cha_o, chb_o, chc_o, chd_o, avg_a_o, avg_b_o, avg_c_o, avg_d_o;
  logic valid_o, avg_valid_o, period_err_o;
  int errs = 0, checks = 0, pulses = 0;
  bpm_deswap_avg dut (
    .clk_sys_i(clk), .rst_n_i(rst_n_i),
    .cha_i(cha_i), .chb_i(chb_i), .chc_i(chc_i), .chd_i(chd_i),
    .valid_i(valid_i), .swap_i(swap_i), .en_i(en_i), .shift_i(shift_i),
    .cha_o(cha_o), .chb_o(chb_o), .chc_o(chc_o), .chd_o(chd_o), .valid_o(valid_o),
    .avg_a_o(avg_a_o), .avg_b_o(avg_b_o), .avg_c_o(avg_c_o), .avg_d_o(avg_d_o),
    .avg_valid_o(avg_valid_o), .period_err_o(period_err_o)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n_i && avg_valid_o) pulses++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic sw, input logic [15:0] a, b, c, d);
    valid_i = 1'b1;
    swap_i = sw;
    cha_i = a;
    chb_i = b;
    chc_i = c;
    chd_i = d;
    tick();
    valid_i = 1'b0;
  endtask
  task automatic gap(input int n);
    valid_i = 1'b0;
    swap_i = 1'b0;
    repeat (n) tick();
  endtask
  // Crossed samples arrive with A and C exchanged on the inputs.
  task automatic per(input int nd, input int nc, input logic [15:0] a_d, a_c, c_d, c_c);
    for (int i = 0; i < nd; i++) send(1'b0, a_d, 16'h0, c_d, 16'h0);
    for (int i = 0; i < nc; i++) send(1'b1, c_c, 16'h0, a_c, 16'h0);
  endtask
  initial begin
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_cha", 32'(cha_o), 0);
    chk("rst_avg_a", 32'(avg_a_o), 0);
    chk("rst_flags", {29'b0, valid_o, avg_valid_o, period_err_o}, 0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    repeat (2) tick();
    rst_n_i = 1'b1;
    tick();
    send(1'b1, 16'h00ff, 16'hff00, 16'hf00f, 16'h0ff0);
    chk("swap_a", 32'(cha_o), 32'h f00f);
    chk("swap_b", 32'(chb_o), 32'h 0ff0);
    chk("swap_c", 32'(chc_o), 32'h 00ff);
    chk("swap_d", 32'(chd_o), 32'h ff00);
    chk("swap_valid", 32'(valid_o), 1);
    send(1'b0, 16'h00ff, 16'hff00, 16'hf00f, 16'h0ff0);
    chk("direct_abcd", {cha_o, chb_o}, 32'h00ffff00);
    chk("direct_cd", {chc_o, chd_o}, 32'hf00f0ff0);
    cha_i = 16'h1234;
    tick();
    chk("hold_a", 32'(cha_o), 32'h00ff);
    chk("hold_valid", 32'(valid_o), 0);
    en_i = 1'b1;
    shift_i = 5'd3;
    tick();
    per(4, 4, 16'd1, 16'd1, 16'd2, 16'd2);
    per(4, 4, 16'd1, 16'd1, 16'd2, 16'd2);
    chk("sync_no_pulse", 32'(pulses), 0);
    per(4, 4, 16'd4, 16'd8, 16'd2, 16'd2);
    chk("avg_a_const", 32'(avg_a_o), 1);
    chk("avg_c_const", 32'(avg_c_o), 2);
    chk("pulses_w1", 32'(pulses), 1);
    send(1'b0, 16'd2, 16'h0, 16'd3, 16'h0);
    chk("avg_valid_hi", 32'(avg_valid_o), 1);
    chk("avg_a_imbal", 32'(avg_a_o), 6);
    chk("avg_c_imbal", 32'(avg_c_o), 2);
    per(3, 2, 16'd2, 16'd2, 16'd3, 16'd3);
    chk("avg_valid_lo", 32'(avg_valid_o), 0);
    gap(5);
    per(0, 2, 16'd2, 16'd2, 16'd3, 16'd3);
    chk("gap_no_close", 32'(pulses), 2);
    send(1'b0, 16'h8000, 16'h0, 16'h7fff, 16'h0);
    shift_i = 5'd2;
    tick();
    chk("gap_avg_a", 32'(avg_a_o), 2);
    chk("gap_pulses", 32'(pulses), 3);
    per(3, 4, 16'h8000, 16'h8000, 16'h7fff, 16'h7fff);
    send(1'b0, 16'h8000, 16'h0, 16'h7fff, 16'h0);
    chk("midshift_ignored", 32'(period_err_o), 0);
    per(1, 2, 16'h8000, 16'h8000, 16'h7fff, 16'h7fff);
    shift_i = 5'd3;
    send(1'b0, 16'd1, 16'h0, 16'd1, 16'h0);
    chk("neg_avg_a", 32'(avg_a_o), 32'h8000);
    chk("pos_avg_c", 32'(avg_c_o), 32'h7fff);
    per(4, 5, 16'd1, 16'd1, 16'd1, 16'd1);
    send(1'b0, 16'd1, 16'h0, 16'd1, 16'h0);
    chk("mismatch_err", 32'(period_err_o), 1);
    per(3, 4, 16'd1, 16'd1, 16'd1, 16'd1);
    send(1'b0, 16'd1, 16'h0, 16'd1, 16'h0);
    tick();
    chk("mismatch_no_pulse", 32'(pulses), 5);
    chk("err_sticky", 32'(period_err_o), 1);
    chk("err_avg_hold", 32'(avg_a_o), 32'h8000);
    en_i = 1'b0;
    tick();
    en_i = 1'b1;
    tick();
    chk("err_cleared", 32'(period_err_o), 0);
    per(4, 4, 16'd5, 16'd5, 16'd5, 16'd5);
    per(2, 0, 16'd5, 16'd5, 16'd5, 16'd5);
    en_i = 1'b0;
    tick();
    chk("dis_state", 32'(dut.state_q), 32'(ST_IDLE));
    en_i = 1'b1;
    tick();
    chk("dis_avg_hold", 32'(avg_a_o), 32'h8000);
    per(4, 4, 16'd7, 16'd7, 16'd1, 16'd1);
    per(4, 4, 16'd7, 16'd7, 16'd1, 16'd1);
    chk("reen_no_early", 32'(pulses), 5);
    send(1'b0, 16'd7, 16'h0, 16'd1, 16'h0);
    chk("reen_pulse", 32'(avg_valid_o), 1);
    chk("reen_avg_a", 32'(avg_a_o), 7);
    send(1'b0, 16'd7, 16'h0, 16'd1, 16'h0);
    chk("reen_pulses", 32'(pulses), 6);
    #2 rst_n_i = 1'b0;
    #1;
    chk("arst_out", {cha_o, avg_a_o}, 0);
    chk("arst_flags", {29'b0, valid_o, avg_valid_o, period_err_o}, 0);
    chk("arst_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("arst_cnt", 32'(dut.cnt_q), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bpm_deswap_avg.md
BPM_DESWAP_AVG -- requirements
Module: bpm_deswap_avg

Interface
REQ-001 Parameter ADC_WIDTH, default 16, signed ADC sample width.
REQ-002 Parameter ACC_WIDTH, default 32, accumulator width; it SHALL be at least ADC_WIDTH+1.
REQ-003 clk_sys_i  in  1  system clock; the block SHALL use this single clock and no other.
REQ-004 rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 cha_i, chb_i, chc_i, chd_i  in  ADC_WIDTH each  signed samples from the swap stage.
REQ-006 valid_i  in  1  sample strobe.
REQ-007 swap_i  in  1  swap phase of the current sample: 0 = direct, 1 = crossed.
REQ-008 en_i  in  1  averager enable.
REQ-009 shift_i  in  5  log2 of the expected samples per full swap period.
REQ-010 cha_o..chd_o  out  ADC_WIDTH each  deswapped instantaneous samples; valid_o  out  1.
REQ-011 avg_a_o..avg_d_o  out  ADC_WIDTH each  per-period averages; avg_valid_o  out  1.
REQ-012 period_err_o  out  1  sticky flag for a window-length mismatch.

Function
REQ-013 Deswap path SHALL be registered with 1-cycle latency; valid_o SHALL equal valid_i delayed by 1 cycle.
REQ-014 With swap_i=0, outputs SHALL pass straight through (a->a, b->b, c->c, d->d).
REQ-015 With swap_i=1, outputs SHALL be exchanged: cha_o=chc_i, chc_o=cha_i, chb_o=chd_i, chd_o=chb_i.
REQ-016 When valid_i=0, data outputs SHALL hold their previous values.
REQ-017 FSM states: IDLE, SYNC, ACC.
REQ-018 IDLE: when en_i=1, go to SYNC; accumulators and count SHALL be cleared.
REQ-019 SYNC: a period start is a valid sample with swap_i=0 whose previous valid sample had swap_i=1.
REQ-020 SYNC: on a period start, go to ACC; that sample SHALL be loaded into the accumulators with count=1.
REQ-021 ACC: each valid deswapped sample SHALL be added, sign-extended to ACC_WIDTH, into its channel accumulator.
REQ-022 ACC: each valid sample SHALL increment count, saturating at all-ones.
REQ-023 ACC, on a period start with count == 2^shift_eff: avg_x_o SHALL become sum_x arithmetically shifted right by shift_eff, truncated to ADC_WIDTH.
REQ-024 In that case avg_valid_o SHALL pulse high for 1 cycle, the cycle after the closing sample.
REQ-025 ACC, on a period start with count != 2^shift_eff: period_err_o SHALL set and stay set, with no avg_valid_o pulse.
REQ-026 The closing sample of every window SHALL start the next window (count=1); no sample is dropped.
REQ-027 shift_eff SHALL be min(shift_i, ACC_WIDTH-ADC_WIDTH), captured at each window start; changes mid-window SHALL be ignored.
REQ-028 en_i=0 in any state SHALL return to IDLE next cycle; the partial window is discarded and avg_x_o keep their last values.
REQ-029 period_err_o SHALL clear only on reset or on an en_i 0->1 transition.
REQ-030 The previous-phase tracker SHALL update only on valid samples, so gaps in valid_i SHALL NOT create false period starts.

Reset
REQ-031 Asynchronous assertion of rst_n_i SHALL force: all data outputs 0, valid_o, avg_valid_o and period_err_o 0, FSM IDLE, accumulators and count 0, previous-phase tracker 0.
REQ-032 A reset applied mid-window SHALL discard that window entirely.
REQ-033 Reset deassertion SHALL be synchronised to clk_sys_i by the integrating level; the block itself SHALL use rst_n_i directly.

Structure
REQ-034 The FSM state enumeration and the default ADC_WIDTH/ACC_WIDTH constants SHALL live in the shared BPM package next to the swap-stage definitions.
REQ-035 One sub-module, bpm_deswap_acc, SHALL implement a single-channel accumulator with clear/load/add controls and SHALL be instantiated four times.

Verification
REQ-036 Deswap: A=0x00ff, B=0xff00, C=0xf00f, D=0x0ff0. With swap_i=1 -> next cycle A_o=0xf00f, B_o=0x0ff0, C_o=0x00ff, D_o=0xff00. With swap_i=0 -> outputs equal inputs.
REQ-037 Average: shift_i=3, period 4 direct + 4 crossed samples, constant A=1, C=2 -> avg_a_o=1, avg_c_o=2. With in-phase imbalance A=4 during direct and C=8 during crossed -> avg_a_o=6.
REQ-038 Mismatch: shift_i=3, period of 10 samples -> period_err_o=1, no avg_valid_o pulse, and the next correct period still produces no pulse unless en_i is toggled.
REQ-039 Gaps: valid_i low for 5 cycles inside the crossed phase -> no extra window closes; avg_valid_o pulses once per period.
REQ-040 Negative samples: A=0x8000 constant, shift_i=2 -> avg_a_o=0x8000 (sign preserved).
REQ-041 Reset and enable: rst_n_i low mid-ACC -> all outputs 0 immediately, FSM IDLE; en_i dropped mid-window -> avg_x_o hold, first post-re-enable avg_valid_o appears only after a full SYNC+period.
